conv_layer_seq: RTL and testbench
=================================

# conv_layer_seq

Layer-level scheduler for one convolution layer mapped onto CIM crossbar tiles. It walks every output-feature-map position in raster order and sequences three steps per position: window fetch from the input buffer, the transfer into the crossbars by the conv input controller, and the CIM compute. It sits above the conv input controller and CIM tiles, and below the network-level layer sequencer, which issues one start per layer.

## Interface
Parameters:
- `image_width`, 8: input feature map width (pixels)
- `image_height`, 8: input feature map height
- `kernel_dim`, 3: square kernel size; stride 1, no padding
- `out_w` (localparam) = image_width-kernel_dim+1; `out_h` = image_height-kernel_dim+1
- `row_w`/`col_w` (localparam) = max(1, $clog2(out_h)) / max(1, $clog2(out_w))

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `i_start`  in  1  layer start; sampled in IDLE only
- `o_busy`  out  1  high from the cycle after start until DONE is left
- `o_done`  out  1  one-cycle pulse after last position completes
- `o_win_req`  out  1  request window for (`o_row`,`o_col`) from input buffer
- `i_win_valid`  in  1  input buffer: window for current position present
- `o_row`  out  row_w  current output row
- `o_col`  out  col_w  current output column
- `o_ctrl_start`  out  1  one-cycle pulse: conv input controller begins crossbar write
- `i_ctrl_busy`  in  1  conv input controller busy
- `o_cim_start`  out  1  one-cycle pulse: crossbars compute
- `i_cim_busy`  in  1  CIM tiles busy

## Operation
- All outputs are Moore, decoded from registered state and counters.
- States:
  - IDLE: if `i_start`, go to WIN.
  - WIN: `o_win_req`=1. If `i_win_valid`, go to LOAD.
  - LOAD: `o_ctrl_start`=1, then LOAD_ACK.
  - LOAD_ACK: wait for `i_ctrl_busy`=1, then LOAD_WAIT.
  - LOAD_WAIT: wait for `i_ctrl_busy`=0, then EXEC.
  - EXEC: `o_cim_start`=1, then EXEC_ACK.
  - EXEC_ACK: wait for `i_cim_busy`=1, then EXEC_WAIT.
  - EXEC_WAIT: wait for `i_cim_busy`=0, then NEXT.
  - NEXT: advance position. Go to DONE if it was last, else WIN.
  - DONE: `o_done`=1, then IDLE.
- Position counter:
  - `o_col` increments in NEXT. At out_w-1 it wraps to 0 and `o_row` increments.
  - Last position = (out_h-1, out_w-1); it clears both counters to 0.
- `o_busy`=1 in every state except IDLE. It is 1 in DONE.
- `i_start` outside IDLE is ignored; no restart and no queueing.
- Busy inputs that are already high in LOAD/EXEC are fine: the ACK state exits on the next cycle.
- `i_win_valid` is level-sensitive and only looked at in WIN.
- Degenerate size out_w=out_h=1: a single position, then DONE.

## Timing
- Reset values: state IDLE, `o_row`=`o_col`=0, all 1-bit outputs 0. They take effect the cycle after `rst` is sampled high.
- Reset mid-operation aborts immediately. No pulse is emitted on abort.
- Start latency: `i_start` sampled in cycle t. `o_busy` and `o_win_req` are high in t+1.
- Minimum per-position latency, with `i_win_valid` already high and each busy raising 1 cycle after its start pulse and dropping 1 cycle later: 8 cycles, WIN through NEXT.
- `o_ctrl_start` and `o_cim_start` are exactly 1 cycle wide, once per position.
- `o_done` comes 1 cycle after NEXT of the last position. `o_busy` drops the cycle after `o_done`.
- `o_row`/`o_col` are stable from WIN to NEXT of a position. They change only on the edge leaving NEXT.

## Structure
- Shared package `cim_pkg`: `seq_state_t` enum. Its distinct name avoids clashing with the existing unscoped `state` typedef.
- Sub-module `pos_counter`: raster row/col counter. Parameters: width, height. Inputs: `clk`, `rst`, `i_advance`. Outputs: `o_row`, `o_col`, `o_last`.
- The top holds the FSM only. Expected size is about 150–220 lines total.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles with `i_start`=1 → all outputs 0. `i_start`=1 then gives `o_busy`=1 and `o_win_req`=1 one cycle later.
- **Full layer:** image 4x4, kernel 3, responders at 1-cycle latency → 4 positions in order (0,0),(0,1),(1,0),(1,1). 4 `o_ctrl_start` and 4 `o_cim_start` pulses; `o_done` at cycle 33 after start.
- **Window stall:** hold `i_win_valid`=0 for 10 cycles at position (0,1) → stays in WIN with `o_win_req`=1 and no `o_ctrl_start`. It proceeds 1 cycle after valid rises.
- **Slow CIM:** `i_cim_busy` high for 20 cycles → no advance and no further pulses. `o_col` advances exactly once after busy drops.
- **Reset mid-operation:** `rst` during EXEC_WAIT of position (1,0) → next cycle IDLE, counters 0, no `o_done`. A new start restarts at (0,0).
- **Ignored start and degenerate size:** `i_start` pulsed while busy has no effect. With image 3x3, kernel 3 → single position and `o_done` after 1 load+compute.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared types for the CIM layer scheduling blocks.
package cim_pkg;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_WIN,
    SEQ_LOAD,
    SEQ_LOAD_ACK,
    SEQ_LOAD_WAIT,
    SEQ_EXEC,
    SEQ_EXEC_ACK,
    SEQ_EXEC_WAIT,
    SEQ_NEXT,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/conv_layer_seq_pos_counter.sv
// Raster-order row/column counter over the output feature map.
module pos_counter #(
  parameter int width = 2,
  parameter int height = 2,
  localparam int col_w = (width > 1) ? $clog2(width) : 1,
  localparam int row_w = (height > 1) ? $clog2(height) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  output logic [row_w-1:0] o_row,
  output logic [col_w-1:0] o_col,
  output logic             o_last
);

  localparam logic [row_w-1:0] row_max = row_w'(height - 1);
  localparam logic [col_w-1:0] col_max = col_w'(width - 1);

  assign o_last = (o_row == row_max) && (o_col == col_max);

  // The last position wraps both counters so the next layer starts at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      o_row <= '0;
      o_col <= '0;
    end else if (i_advance) begin
      if (o_last) begin
        o_row <= '0;
        o_col <= '0;
      end else if (o_col == col_max) begin
        o_col <= '0;
        o_row <= o_row + row_w'(1);
      end else begin
        o_col <= o_col + col_w'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// Layer scheduler: per output position, fetch window, load crossbars, compute.
module conv_layer_seq
  import cim_pkg::*;
#(
  parameter int image_width = 8,
  parameter int image_height = 8,
  parameter int kernel_dim = 3,
  localparam int out_w = image_width - kernel_dim + 1,
  localparam int out_h = image_height - kernel_dim + 1,
  localparam int row_w = (out_h > 1) ? $clog2(out_h) : 1,
  localparam int col_w = (out_w > 1) ? $clog2(out_w) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_win_req,
  input  logic             i_win_valid,
  output logic [row_w-1:0] o_row,
  output logic [col_w-1:0] o_col,
  output logic             o_ctrl_start,
  input  logic             i_ctrl_busy,
  output logic             o_cim_start,
  input  logic             i_cim_busy
);

  seq_state_t state, state_next;
  logic       pos_last;

  pos_counter #(
    .width (out_w),
    .height(out_h)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .i_advance(state == SEQ_NEXT),
    .o_row    (o_row),
    .o_col    (o_col),
    .o_last   (pos_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_next;
  end

  // ACK states catch the responder's busy rising; WAIT states catch it falling.
  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE:      if (i_start)      state_next = SEQ_WIN;
      SEQ_WIN:       if (i_win_valid)  state_next = SEQ_LOAD;
      SEQ_LOAD:                        state_next = SEQ_LOAD_ACK;
      SEQ_LOAD_ACK:  if (i_ctrl_busy)  state_next = SEQ_LOAD_WAIT;
      SEQ_LOAD_WAIT: if (!i_ctrl_busy) state_next = SEQ_EXEC;
      SEQ_EXEC:                        state_next = SEQ_EXEC_ACK;
      SEQ_EXEC_ACK:  if (i_cim_busy)   state_next = SEQ_EXEC_WAIT;
      SEQ_EXEC_WAIT: if (!i_cim_busy)  state_next = SEQ_NEXT;
      SEQ_NEXT:      state_next = pos_last ? SEQ_DONE : SEQ_WIN;
      SEQ_DONE:                        state_next = SEQ_IDLE;
      default:                         state_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state != SEQ_IDLE);
    o_done       = (state == SEQ_DONE);
    o_win_req    = (state == SEQ_WIN);
    o_ctrl_start = (state == SEQ_LOAD);
    o_cim_start  = (state == SEQ_EXEC);
  end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: 4x4 image (2x2 positions) and degenerate 3x3 image.
module tb_conv_layer_seq;

  logic clk = 1'b0;
  logic rst;
  logic start, win_valid, ctrl_busy, cim_busy;
  logic busy, done, win_req, ctrl_start, cim_start;
  logic [0:0] row, col;
  logic start3, valid3, cbusy3, mbusy3;
  logic busy3, done3, win3, ctrl3, cim3;
  logic [0:0] row3, col3;

  int errors = 0;
  int checks = 0;
  int ctrl_len = 1;
  int cim_len = 1;

  always #5 clk = ~clk;

  conv_layer_seq #(.image_width(4), .image_height(4), .kernel_dim(3)) dut4 (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_win_req(win_req), .i_win_valid(win_valid), .o_row(row), .o_col(col),
    .o_ctrl_start(ctrl_start), .i_ctrl_busy(ctrl_busy),
    .o_cim_start(cim_start), .i_cim_busy(cim_busy)
  );

  conv_layer_seq #(.image_width(3), .image_height(3), .kernel_dim(3)) dut3 (
    .clk(clk), .rst(rst), .i_start(start3), .o_busy(busy3), .o_done(done3),
    .o_win_req(win3), .i_win_valid(valid3), .o_row(row3), .o_col(col3),
    .o_ctrl_start(ctrl3), .i_ctrl_busy(cbusy3),
    .o_cim_start(cim3), .i_cim_busy(mbusy3)
  );

  // Responders raise busy one cycle after each start pulse and hold it for *_len cycles.
  initial begin
    ctrl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_start) begin
        @(posedge clk); #1; ctrl_busy = 1'b1;
        repeat (ctrl_len) @(posedge clk);
        #1; ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    cim_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cim_start) begin
        @(posedge clk); #1; cim_busy = 1'b1;
        repeat (cim_len) @(posedge clk);
        #1; cim_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v);
    start = s;
    win_valid = v;
    @(negedge clk);
  endtask

  // which=0 waits for a window request, which=1 for a compute pulse, at position (r,c).
  task automatic wait_cond(input int which, input logic r, input logic c, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (((which == 0) ? win_req : cim_start) && row == r && col == c) found = 1'b1;
    end
  endtask

  // Runs one layer with start already high; k counts cycles after start is sampled.
  task automatic run_layer(input bit poke, output int done_cyc, output int n_done,
                           output int n_ctrl, output int n_cim, output logic [7:0] seq,
                           output logic [7:0] cseq, output logic [3:0] first,
                           output logic [1:0] after);
    done_cyc = 0; n_done = 0; n_ctrl = 0; n_cim = 0;
    seq = '0; cseq = '0; first = '0; after = '1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        first = {busy, win_req, row, col};
        start = 1'b0;
      end
      if (ctrl_start) begin n_ctrl++; seq = {seq[5:0], row, col}; end
      if (cim_start) begin n_cim++; cseq = {cseq[5:0], row, col}; end
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (poke && (k == 5 || k == 33)) start = 1'b1;
      if (k == 6 || k == 34) start = 1'b0;
      if (k == 35) after = {busy, done};
    end
  endtask

  int done_cyc, n_done, n_ctrl, n_cim, stall_ok, hold_bad;
  logic [7:0] seq, cseq;
  logic [3:0] first;
  logic [1:0] after;
  bit found;
  logic [4:0] exp3 [10] = '{5'b10100, 5'b10010, 5'b10000, 5'b10000, 5'b10001,
                            5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b00000};

  initial begin
    rst = 1'b1;
    start3 = 1'b0; valid3 = 1'b1; cbusy3 = 1'b0; mbusy3 = 1'b0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_outputs", {busy, done, win_req, ctrl_start, cim_start, row, col}, '0);
    checkOutput("reset_outputs_deg", {busy3, done3, win3, ctrl3, cim3, row3, col3}, '0);

    $display("[TB] full layer 4x4");
    rst = 1'b0;
    run_layer(1'b0, done_cyc, n_done, n_ctrl, n_cim, seq, cseq, first, after);
    checkOutput("start_latency", first, 4'b1100);
    checkOutput("done_cycle", done_cyc, 33);
    checkOutput("done_width", n_done, 1);
    checkOutput("ctrl_pulses", n_ctrl, 4);
    checkOutput("cim_pulses", n_cim, 4);
    checkOutput("ctrl_order", seq, 8'h1B);
    checkOutput("cim_order", cseq, 8'h1B);
    checkOutput("busy_after_done", after, 2'b00);

    $display("[TB] window stall and slow compute");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    wait_cond(0, 1'b0, 1'b1, found);
    checkOutput("reach_win_01", found, 1);
    win_valid = 1'b0;
    stall_ok = 0;
    repeat (10) begin
      @(negedge clk);
      if (win_req && !ctrl_start && row == 1'b0 && col == 1'b1) stall_ok++;
    end
    checkOutput("stall_hold", stall_ok, 10);
    win_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_release", {ctrl_start, row, col}, 3'b101);
    cim_len = 20;
    wait_cond(1, 1'b0, 1'b1, found);
    checkOutput("reach_exec_01", found, 1);
    hold_bad = 0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k <= 22 && !(row == 1'b0 && col == 1'b1 && !ctrl_start && !cim_start && !win_req)) hold_bad++;
      if (k == 5) cim_len = 1;
      if (k == 23) checkOutput("slow_advance", {win_req, row, col}, 3'b110);
    end
    checkOutput("slow_hold", hold_bad, 0);

    $display("[TB] reset mid-operation");
    wait_cond(1, 1'b1, 1'b0, found);
    checkOutput("reach_exec_10", found, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_outputs", {busy, done, win_req, ctrl_start, cim_start, row, col}, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_stays_idle", {busy, done}, 2'b00);

    $display("[TB] restart with ignored starts");
    start = 1'b1;
    run_layer(1'b1, done_cyc, n_done, n_ctrl, n_cim, seq, cseq, first, after);
    checkOutput("restart_pos", first, 4'b1100);
    checkOutput("restart_done_cycle", done_cyc, 33);
    checkOutput("restart_done_count", n_done, 1);
    checkOutput("restart_ctrl_pulses", n_ctrl, 4);
    checkOutput("restart_order", seq, 8'h1B);
    checkOutput("no_queued_start", after, 2'b00);

    $display("[TB] degenerate 3x3");
    start3 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start3 = 1'b0;
      checkOutput($sformatf("deg_k%0d", k), {busy3, done3, win3, ctrl3, cim3, row3, col3},
                  {25'd0, exp3[k-1], 2'b00});
      cbusy3 = (k == 3);
      mbusy3 = (k == 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
